// File: rtl/h_encoder_64_57_stream.sv
// Streaming Hamming (64,57) SECDED encoder with optional per-word error injection.
// Produces codewords in the layout consumed by h_decoder_64_57:
//   cw[3]=d[0], cw[7:5]=d[3:1], cw[15:9]=d[10:4], cw[31:17]=d[25:11], cw[63:33]=d[56:26],
//   cw[2^k] = even Hamming parity over data positions with bit k set, cw[0] = XOR of cw[63:1].
// Two-stage valid/ready pipeline: stage 1 holds data bits, Hamming parities and injection
// controls; stage 2 adds overall parity, applies the injected flips and drives the outputs.
// Ports:
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_Data, i_Valid     upstream 57-bit word and its valid
//   o_Ready             combinational accept indication to upstream
//   i_InjEn             flip codeword bit i_InjPos1 of this word
//   i_InjDouble         also flip i_InjPos2 (only if it differs from i_InjPos1)
//   i_InjPos1/2         flip positions 0..63
//   o_CodeWord, o_Valid registered downstream word and its valid
//   i_Ready             downstream accept
//   o_WordCnt           registered count of output handshakes, wraps at 16 bits
module h_encoder_64_57_stream (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [56:0] i_Data,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic        i_InjEn,
  input  logic        i_InjDouble,
  input  logic [5:0]  i_InjPos1,
  input  logic [5:0]  i_InjPos2,
  output logic [63:0] o_CodeWord,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [15:0] o_WordCnt
);

  // Stage 1 state
  logic        v1_q, v1_d;
  logic [63:1] cw1_q, cw1_d;
  logic        inj_en1_q, inj_dbl1_q;
  logic [5:0]  pos1_1_q, pos2_1_q;

  // Stage 2 state
  logic        v2_q, v2_d;
  logic [63:0] cw2_q, cw2_d;
  logic [15:0] cnt_q, cnt_d;

  logic stall2, ready1, accept, emit;

  assign stall2  = v2_q && !i_Ready;
  assign ready1  = !v1_q || !stall2;
  assign accept  = i_Valid && ready1;
  assign emit    = v2_q && i_Ready;
  assign o_Ready = ready1;

  // Stage 1: place data bits and compute the six Hamming parities.
  logic [63:0] spread;
  logic [5:0]  ham;
  always_comb begin
    spread        = '0;
    spread[3]     = i_Data[0];
    spread[7:5]   = i_Data[3:1];
    spread[15:9]  = i_Data[10:4];
    spread[31:17] = i_Data[25:11];
    spread[63:33] = i_Data[56:26];
    ham = '0;
    // Parity positions hold 0 in spread, so XORing every position with bit k set
    // only picks up data bits.
    for (int unsigned k = 0; k < 6; k++) begin
      for (int unsigned pos = 1; pos < 64; pos++) begin
        if (pos[k]) ham[k] = ham[k] ^ spread[pos[5:0]];
      end
    end
    cw1_d     = spread[63:1];
    cw1_d[1]  = ham[0];
    cw1_d[2]  = ham[1];
    cw1_d[4]  = ham[2];
    cw1_d[8]  = ham[3];
    cw1_d[16] = ham[4];
    cw1_d[32] = ham[5];
  end

  // Stage 2: overall parity first, then injected flips on top of the final codeword.
  logic [63:0] flip;
  always_comb begin
    flip = '0;
    if (inj_en1_q) begin
      flip[pos1_1_q] = 1'b1;
      if (inj_dbl1_q && (pos2_1_q != pos1_1_q)) flip[pos2_1_q] = 1'b1;
    end
    cw2_d = {cw1_q, ^cw1_q} ^ flip;
  end

  always_comb begin
    v1_d  = ready1 ? i_Valid : v1_q;
    v2_d  = stall2 ? v2_q : v1_q;
    cnt_d = emit ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      v1_q       <= 1'b0;
      cw1_q      <= '0;
      inj_en1_q  <= 1'b0;
      inj_dbl1_q <= 1'b0;
      pos1_1_q   <= '0;
      pos2_1_q   <= '0;
      v2_q       <= 1'b0;
      cw2_q      <= '0;
      cnt_q      <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      cnt_q <= cnt_d;
      if (accept) begin
        cw1_q      <= cw1_d;
        inj_en1_q  <= i_InjEn;
        inj_dbl1_q <= i_InjDouble;
        pos1_1_q   <= i_InjPos1;
        pos2_1_q   <= i_InjPos2;
      end
      if (!stall2 && v1_q) cw2_q <= cw2_d;
    end
  end

  assign o_CodeWord = cw2_q;
  assign o_Valid    = v2_q;
  assign o_WordCnt  = cnt_q;

endmodule

// File: tb/tb_h_encoder_64_57_stream.sv
module tb_h_encoder_64_57_stream;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic [56:0] i_Data;
  logic        i_Valid;
  logic        o_Ready;
  logic        i_InjEn;
  logic        i_InjDouble;
  logic [5:0]  i_InjPos1;
  logic [5:0]  i_InjPos2;
  logic [63:0] o_CodeWord;
  logic        o_Valid;
  logic        i_Ready;
  logic [15:0] o_WordCnt;

  h_encoder_64_57_stream dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Data(i_Data), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_InjEn(i_InjEn), .i_InjDouble(i_InjDouble), .i_InjPos1(i_InjPos1), .i_InjPos2(i_InjPos2),
    .o_CodeWord(o_CodeWord), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_WordCnt(o_WordCnt)
  );

  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: data fills non-power-of-two positions in ascending order,
  // each parity bit makes its covered group even, bit 0 makes the whole word even.
  function automatic logic [63:0] ref_enc(input logic [56:0] d, input logic en, input logic dbl,
                                          input logic [5:0] p1, input logic [5:0] p2);
    logic [63:0] cw;
    int j;
    logic par;
    cw = '0;
    j = 0;
    for (int pos = 1; pos < 64; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int pos = 1; pos < 64; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) par = par ^ cw[pos];
      cw[1 << k] = par;
    end
    par = 1'b0;
    for (int pos = 1; pos < 64; pos++) par = par ^ cw[pos];
    cw[0] = par;
    if (en) begin
      cw[p1] = ~cw[p1];
      if (dbl && p2 != p1) cw[p2] = ~cw[p2];
    end
    return cw;
  endfunction

  typedef struct {
    logic [56:0] d;
    logic        en;
    logic        dbl;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  logic [63:0] sb[$];
  logic        prev_stall;
  logic [63:0] prev_cw;
  int          n_acc;

  task automatic idle_inputs();
    i_Valid = 1'b0; i_Data = '0; i_InjEn = 1'b0; i_InjDouble = 1'b0;
    i_InjPos1 = '0; i_InjPos2 = '0;
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    idle_inputs();
    i_Ready = 1'b1;
    @(posedge i_Clk); @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
  endtask

  // One clock cycle of scoreboarded streaming; called #1 after a rising edge.
  task automatic cycle(input logic v, input logic [56:0] d, input logic en, input logic dbl,
                       input logic [5:0] p1, input logic [5:0] p2, input logic rdy);
    logic acc;
    i_Valid = v; i_Data = d; i_InjEn = en; i_InjDouble = dbl;
    i_InjPos1 = p1; i_InjPos2 = p2; i_Ready = rdy;
    #3;
    if (prev_stall) begin
      check("held_valid", {63'd0, o_Valid}, 64'd1);
      check("held_word", o_CodeWord, prev_cw);
    end
    // Two words in flight means both stages are full.
    check("o_ready", {63'd0, o_Ready}, {63'd0, !(sb.size() == 2 && !rdy)});
    acc = v && o_Ready;
    if (o_Valid && rdy) begin
      if (sb.size() == 0) check("unexpected_out", o_CodeWord, 64'hx);
      else check("stream_word", o_CodeWord, sb.pop_front());
    end
    if (acc) begin
      sb.push_back(ref_enc(d, en, dbl, p1, p2));
      n_acc++;
    end
    prev_stall = o_Valid && !rdy;
    prev_cw    = o_CodeWord;
    @(posedge i_Clk); #1;
  endtask

  initial begin
    int bound;
    int n_out;
    logic [1:0] rdy_pat;

    vecs[0] = '{57'h0, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0};
    vecs[1] = '{57'h1FF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 6'd0, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{57'h1, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0000_0000_0000_000F};
    // d[1] lands at position 5 (binary 101): parities 1 and 4 plus overall parity.
    vecs[3] = '{57'h2, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0000_0000_0000_0033};
    vecs[4] = '{57'h0, 1'b1, 1'b0, 6'd5, 6'd0, 64'h20};
    vecs[5] = '{57'h0, 1'b1, 1'b1, 6'd5, 6'd63, 64'h8000_0000_0000_0020};
    vecs[6] = '{57'h0, 1'b1, 1'b1, 6'd5, 6'd5, 64'h20};
    vecs[7] = '{57'h1, 1'b0, 1'b1, 6'd7, 6'd9, 64'h0000_0000_0000_000F};

    do_reset();
    #3;
    check("rst_valid", {63'd0, o_Valid}, 64'd0);
    check("rst_cw", o_CodeWord, 64'h0);
    check("rst_cnt", {48'd0, o_WordCnt}, 64'd0);
    check("rst_ready", {63'd0, o_Ready}, 64'd1);
    @(posedge i_Clk); #1;

    // Directed vectors: latency N+2 and exact codewords.
    for (int i = 0; i < 8; i++) begin
      check("model_vs_table", ref_enc(vecs[i].d, vecs[i].en, vecs[i].dbl, vecs[i].p1, vecs[i].p2),
            vecs[i].exp);
      i_Valid = 1'b1; i_Data = vecs[i].d; i_InjEn = vecs[i].en; i_InjDouble = vecs[i].dbl;
      i_InjPos1 = vecs[i].p1; i_InjPos2 = vecs[i].p2; i_Ready = 1'b1;
      #3;
      check("vec_accept", {63'd0, o_Ready}, 64'd1);
      @(posedge i_Clk); #1;
      idle_inputs();
      #3;
      check("vec_n1_valid", {63'd0, o_Valid}, 64'd0);
      @(posedge i_Clk); #4;
      check("vec_n2_valid", {63'd0, o_Valid}, 64'd1);
      check("vec_word", o_CodeWord, vecs[i].exp);
      @(posedge i_Clk); #1;
    end
    check("vec_cnt", {48'd0, o_WordCnt}, 64'd8);

    // Backpressure: 8 random words, i_Ready pattern 1,0,0,1 repeating.
    do_reset();
    n_acc = 0;
    bound = 0;
    rdy_pat = 2'd0;
    while ((n_acc < 8 || sb.size() != 0) && bound < 200) begin
      cycle(n_acc < 8, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
            6'($urandom), 6'($urandom), (rdy_pat == 2'd0 || rdy_pat == 2'd3));
      rdy_pat++;
      bound++;
    end
    check("bp_drained", {63'd0, bound < 200}, 64'd1);
    check("bp_cnt", {48'd0, o_WordCnt}, 64'd8);

    // Reset with two words in flight.
    n_acc = 0;
    cycle(1'b1, 57'h123, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
    cycle(1'b1, 57'h456, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
    cycle(1'b0, 57'h0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
    check("mid_inflight", 64'(sb.size()), 64'd2);
    i_Rst = 1'b1;
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    i_Ready = 1'b1;
    #3;
    check("mid_rst_valid", {63'd0, o_Valid}, 64'd0);
    check("mid_rst_cnt", {48'd0, o_WordCnt}, 64'd0);
    check("mid_rst_ready", {63'd0, o_Ready}, 64'd1);
    @(posedge i_Clk); #4;
    check("mid_rst_no_out", {63'd0, o_Valid}, 64'd0);
    @(posedge i_Clk); #1;
    sb.delete();
    prev_stall = 1'b0;

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
            6'($urandom), 6'($urandom), ($urandom_range(0, 3) != 0));
    bound = 0;
    while (sb.size() != 0 && bound < 10) begin
      cycle(1'b0, 57'h0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      bound++;
    end
    check("rand_drained", 64'(sb.size()), 64'd0);

    // Counter wrap after 65536 handshakes.
    do_reset();
    i_Valid = 1'b1; i_Ready = 1'b1;
    n_out = 0;
    bound = 0;
    while (n_out < 65536 && bound < 70000) begin
      #3;
      if (o_Valid && i_Ready) n_out++;
      if (n_out == 65535) begin
        @(posedge i_Clk); #1;
        check("cnt_ffff", {48'd0, o_WordCnt}, 64'hFFFF);
        #3;
        if (o_Valid && i_Ready) n_out++;
      end
      @(posedge i_Clk); #1;
      bound++;
    end
    i_Valid = 1'b0; i_Ready = 1'b0;
    check("wrap_reached", 64'(n_out), 64'd65536);
    #3;
    check("cnt_wrap", {48'd0, o_WordCnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
